tile_shuffler: RTL and testbench

TILE_SHUFFLER -- requirements
Module: tile_shuffler

---
 rtl/tile_pkg.sv | 27 ++
 rtl/lfsr16.sv | 36 +++
 rtl/tile_shuffler.sv | 116 +++++++++++
 tb/tb_tile_shuffler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants, state encoding and LFSR helpers for the tile shuffler
// and the other random features that reuse lfsr16.
package tile_pkg;

    localparam int          NUM_TILES         = 16;
    localparam int          TILE_W            = 3;
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHUFFLE,
        ST_DONE
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    function automatic logic [15:0] seed_or_default(input logic [15:0] s);
        return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable; reset loads the
// default seed.
module lfsr16
    import tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tile_shuffler.sv
// Builds a board of value pairs 0..7 and permutes it with an LFSR-driven
// Fisher-Yates pass; the board is published only when the pass completes.
module tile_shuffler #(
    parameter int NUM_TILES = tile_pkg::NUM_TILES,
    parameter int TILE_W    = tile_pkg::TILE_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [15:0]                 seed,
    output logic [NUM_TILES*TILE_W-1:0] tiles,
    output logic                        valid,
    output logic                        busy
);
    import tile_pkg::*;

    localparam int IDX_W = $clog2(NUM_TILES);

    state_e                      state_q, state_d;
    logic [TILE_W-1:0]           w_q [NUM_TILES];
    logic [TILE_W-1:0]           w_d [NUM_TILES];
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_TILES*TILE_W-1:0] tiles_q, tiles_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;

    logic                        lfsr_load;
    logic                        lfsr_en;
    logic [15:0]                 lfsr_q;
    logic [IDX_W-1:0]            j;
    logic                        lfsr_unused;

    lfsr16 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (seed_or_default(seed)),
        .en       (lfsr_en),
        .q        (lfsr_q)
    );

    assign j           = lfsr_q[IDX_W-1:0];
    assign lfsr_unused = ^lfsr_q[15:IDX_W];

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        idx_d     = idx_q;
        tiles_d   = tiles_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            ST_FILL: begin
                for (int unsigned k = 0; k < NUM_TILES; k++) begin
                    w_d[k] = TILE_W'(k >> 1);
                end
                idx_d   = IDX_W'(NUM_TILES - 1);
                state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                lfsr_en = 1'b1;
                // Out-of-range draws are rejected and retried on the next step.
                if (j <= idx_q) begin
                    w_d[idx_q] = w_q[j];
                    w_d[j]     = w_q[idx_q];
                    idx_d      = idx_q - IDX_W'(1);
                    if (idx_q == IDX_W'(1)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        for (int unsigned k = 0; k < NUM_TILES; k++) begin
                            tiles_d[k*TILE_W +: TILE_W] = w_d[k];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            w_q     <= '{default: '0};
            idx_q   <= IDX_W'(NUM_TILES - 1);
            tiles_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            tiles_q <= tiles_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign tiles = tiles_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tile_shuffler.sv
// Self-checking bench for tile_shuffler: directed scenarios plus random seeds
// scored against a behavioural Fisher-Yates model.
module tb_tile_shuffler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic [47:0] tiles;
    logic        valid;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tile_shuffler #(.NUM_TILES(16), .TILE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .seed  (seed),
        .tiles (tiles),
        .valid (valid),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rejection-sampled Fisher-Yates over integers; n = draws taken.
    task automatic model(input logic [15:0] s, output logic [47:0] board, output int n);
        int w [16];
        int r, i, j, t;
        r = (s == 16'h0000) ? 'hACE1 : int'(s);
        for (int k = 0; k < 16; k++) w[k] = k / 2;
        i = 15;
        n = 0;
        while (i >= 1 && n < 100000) begin
            j = r % 16;
            n++;
            r = (r / 2) ^ (((r % 2) != 0) ? 'hB400 : 0);
            if (j <= i) begin
                t = w[i]; w[i] = w[j]; w[j] = t;
                i--;
            end
        end
        board = '0;
        for (int k = 0; k < 16; k++) board[k*3 +: 3] = 3'(w[k]);
    endtask

    task automatic run_board(input logic [15:0] s, input bit noisy,
                             output logic [47:0] got, output int lat);
        logic [47:0] prev;
        bit          hold_ok;
        prev    = tiles;
        hold_ok = 1'b1;
        seed    = s;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("valid_after_start", 64'(valid), 64'd0);
        while (lat < 2000) begin
            if (tiles !== prev) hold_ok = 1'b0;
            if (noisy) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (valid) break;
        end
        start = 1'b0;
        got   = tiles;
        check("valid_within_bound", 64'(valid), 64'd1);
        check("tiles_held_while_busy", 64'(hold_ok), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [47:0] ref_b, got, first_b, b0, bace, hold_b;
        int          ref_n, lat;
        int          cnt [8];

        reset = 1'b0;
        start = 1'b0;
        seed  = 16'h0000;
        #12;
        check("reset_tiles", 64'(tiles), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(valid), 64'd0);

        // Seed 0x0001 board, latency and pair histogram
        model(16'h0001, ref_b, ref_n);
        run_board(16'h0001, 1'b0, got, lat);
        check("s1_tiles", 64'(got), 64'(ref_b));
        check("s1_latency", 64'(lat), 64'(ref_n + 1));
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int k = 0; k < 16; k++) cnt[got[k*3 +: 3]]++;
        for (int v = 0; v < 8; v++) check($sformatf("s1_hist_%0d", v), 64'(cnt[v]), 64'd2);
        first_b = got;
        repeat (3) @(posedge clk);
        #1;
        check("done_valid_hold", 64'(valid), 64'd1);
        check("done_tiles_hold", 64'(tiles), 64'(first_b));

        // Determinism across reset and zero-seed substitution
        pulse_reset();
        check("post_reset_tiles", 64'(tiles), 64'd0);
        run_board(16'h0001, 1'b0, got, lat);
        check("s1_repeat", 64'(got), 64'(first_b));
        run_board(16'h0000, 1'b0, b0, lat);
        run_board(16'hACE1, 1'b0, bace, lat);
        check("seed0_eq_ace1", 64'(b0), 64'(bace));
        model(16'hACE1, ref_b, ref_n);
        check("ace1_tiles", 64'(bace), 64'(ref_b));

        // Start pulses during the shuffle are ignored
        model(16'h1234, ref_b, ref_n);
        run_board(16'h1234, 1'b1, got, lat);
        check("noisy_tiles", 64'(got), 64'(ref_b));
        check("noisy_latency", 64'(lat), 64'(ref_n + 1));

        // Reset in the middle of a shuffle after a completed board
        seed  = 16'h5A5A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset_tiles", 64'(tiles), 64'd0);
        check("mid_reset_valid", 64'(valid), 64'd0);
        check("mid_reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_idle_busy", 64'(busy), 64'd0);
        check("mid_idle_tiles", 64'(tiles), 64'd0);
        model(16'h5A5A, ref_b, ref_n);
        run_board(16'h5A5A, 1'b0, got, lat);
        check("after_mid_tiles", 64'(got), 64'(ref_b));

        // start held high: one DONE cycle, then an identical board again
        model(16'hBEEF, ref_b, ref_n);
        seed  = 16'hBEEF;
        start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held_lat1", 64'(lat), 64'(ref_n + 1));
        hold_b = tiles;
        check("held_tiles1", 64'(hold_b), 64'(ref_b));
        @(posedge clk); #1;
        check("held_restart_valid", 64'(valid), 64'd0);
        check("held_restart_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("held_lat2", 64'(lat), 64'(ref_n + 1));
        check("held_tiles2", 64'(tiles), 64'(hold_b));

        // Random seeds against the model
        for (int t = 0; t < 200; t++) begin
            logic [15:0] s;
            s = 16'($urandom);
            model(s, ref_b, ref_n);
            run_board(s, 1'b0, got, lat);
            check($sformatf("rand_tiles_%04h", s), 64'(got), 64'(ref_b));
            check($sformatf("rand_lat_%04h", s), 64'(lat), 64'(ref_n + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
